// File: rtl/msx2_mapper_ctrl.sv
// MSX2 memory mapper control: page segment registers on I/O ports FCh-FFh,
// CPU-to-linear RAM address translation and the RAM request/ack handshake.
`timescale 1ns/1ps
module msx2_mapper_ctrl #(
    parameter int SEG_BITS = 5,
    parameter int RAM_AW   = SEG_BITS + 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic [7:0]        io_addr,
    input  logic [7:0]        io_din,
    output logic [7:0]        io_dout,
    output logic              io_dout_rq,
    input  logic              mem_sel,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [15:0]       mem_addr,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic              mem_dout_valid,
    output logic              cpu_wait,
    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic              ram_ack,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_e;

    logic                port_hit;
    logic                seg_wr;
    logic [SEG_BITS-1:0] seg_q [4];
    logic [SEG_BITS-1:0] seg_d [4];
    logic [7:0]          rd_byte;

    state_e              state_q, state_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [7:0]          ram_wdata_q, ram_wdata_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                accept;

    assign port_hit = (io_addr[7:2] == 6'b111111);
    assign seg_wr   = io_wr && port_hit;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        seg_d = seg_q;
        if (seg_wr) begin
            seg_d[io_addr[1:0]] = io_din[SEG_BITS-1:0];
        end
    end

    // NOTE: the segment file is only four registers and has defined power-up values, so it is reset like any other flop rather than treated as RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q[0] <= SEG_BITS'(3);
            seg_q[1] <= SEG_BITS'(2);
            seg_q[2] <= SEG_BITS'(1);
            seg_q[3] <= SEG_BITS'(0);
        end else begin
            seg_q <= seg_d;
        end
    end

    // Unused upper bits of the readback byte float high, as on real mapper hardware.
    always_comb begin
        rd_byte                 = 8'hFF;
        rd_byte[SEG_BITS-1:0]   = seg_q[io_addr[1:0]];
        io_dout_rq              = io_rd && port_hit;
        io_dout                 = io_dout_rq ? rd_byte : 8'hFF;
    end

    assign accept = (mem_rd || mem_wr) && mem_sel;

    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = ram_we_q;
        ram_wdata_d = ram_wdata_q;
        mem_dout_d  = mem_dout_q;
        cpu_wait    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Old segment value is used even if it is written this same cycle.
                    ram_addr_d  = RAM_AW'({seg_q[mem_addr[15:14]], mem_addr[13:0]});
                    ram_we_d    = mem_wr;
                    ram_wdata_d = mem_din;
                    cpu_wait    = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                cpu_wait = 1'b1;
                if (ram_ack) begin
                    if (!ram_we_q) begin
                        mem_dout_d = ram_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 8'h00;
            mem_dout_q  <= 8'hFF;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            mem_dout_q  <= mem_dout_d;
        end
    end

    // Decoded from state so that reset drops the request and wait without a clock edge.
    assign ram_req        = (state_q == ST_REQ);
    assign mem_dout_valid = (state_q == ST_DONE) && !ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_we         = ram_we_q;
    assign ram_wdata      = ram_wdata_q;
    assign mem_dout       = mem_dout_q;

endmodule

// File: tb/tb_msx2_mapper_ctrl.sv
// Directed self-checking bench for msx2_mapper_ctrl: segment registers,
// read/write handshakes, same-cycle register collision and mid-access reset.
`timescale 1ns/1ps
module tb_msx2_mapper_ctrl;

    localparam int SEG_BITS = 5;
    localparam int RAM_AW   = SEG_BITS + 14;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              io_wr, io_rd;
    logic [7:0]        io_addr, io_din, io_dout;
    logic              io_dout_rq;
    logic              mem_sel, mem_rd, mem_wr;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_din, mem_dout;
    logic              mem_dout_valid, cpu_wait;
    logic              ram_req, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_ack;
    logic [7:0]        ram_rdata;

    int n_vec = 0;
    int n_err = 0;
    int wait_cnt = 0;
    int valid_cnt = 0;

    msx2_mapper_ctrl #(.SEG_BITS(SEG_BITS), .RAM_AW(RAM_AW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .io_wr          (io_wr),
        .io_rd          (io_rd),
        .io_addr        (io_addr),
        .io_din         (io_din),
        .io_dout        (io_dout),
        .io_dout_rq     (io_dout_rq),
        .mem_sel        (mem_sel),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_dout_valid (mem_dout_valid),
        .cpu_wait       (cpu_wait),
        .ram_req        (ram_req),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_ack        (ram_ack),
        .ram_rdata      (ram_rdata)
    );

    always #5 clk = ~clk;

    // Cycle-level counts of wait and valid, sampled mid-cycle.
    always @(negedge clk) begin
        if (cpu_wait)       wait_cnt  <= wait_cnt + 1;
        if (mem_dout_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_port(input logic [7:0] addr, input logic exp_rq, input logic [7:0] exp_dout);
        io_addr = addr;
        io_rd   = 1'b1;
        #1;
        check($sformatf("rq_%0h", addr), 32'(io_dout_rq), 32'(exp_rq));
        check($sformatf("dout_%0h", addr), 32'(io_dout), 32'(exp_dout));
        io_rd = 1'b0;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        io_wr   = 1'b1;
        io_addr = addr;
        io_din  = data;
        tick();
        io_wr = 1'b0;
    endtask

    // One complete memory access; ram_ack is given in REQ cycle number req_cycles.
    // With poke set, seg0 is rewritten during the first REQ cycle.
    task automatic access(input logic wr, input logic [15:0] addr, input logic [7:0] din,
                          input int req_cycles, input logic [7:0] rdata,
                          input logic [RAM_AW-1:0] exp_addr, input logic poke);
        int w0, v0;
        w0 = wait_cnt;
        v0 = valid_cnt;
        mem_sel  = 1'b1;
        mem_rd   = !wr;
        mem_wr   = wr;
        mem_addr = addr;
        mem_din  = din;
        #1;
        check("strobe_wait", 32'(cpu_wait), 32'd1);
        tick();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        io_wr  = 1'b0;
        check("req", 32'(ram_req), 32'd1);
        check("addr", 32'(ram_addr), 32'(exp_addr));
        check("we", 32'(ram_we), 32'(wr));
        if (wr) check("wdata", 32'(ram_wdata), 32'(din));
        for (int i = 1; i < req_cycles; i++) begin
            if (poke && i == 1) begin
                io_wr   = 1'b1;
                io_addr = 8'hFC;
                io_din  = 8'h00;
            end
            tick();
            io_wr = 1'b0;
            check("addr_held", 32'(ram_addr), 32'(exp_addr));
        end
        ram_ack   = 1'b1;
        ram_rdata = rdata;
        tick();
        ram_ack = 1'b0;
        check("done_wait", 32'(cpu_wait), 32'd0);
        check("done_req", 32'(ram_req), 32'd0);
        check("done_valid", 32'(mem_dout_valid), 32'(!wr));
        if (!wr) check("rdata", 32'(mem_dout), 32'(rdata));
        tick();
        check("idle_valid", 32'(mem_dout_valid), 32'd0);
        check("wait_cycles", 32'(wait_cnt - w0), 32'(1 + req_cycles));
        check("valid_pulses", 32'(valid_cnt - v0), 32'(!wr));
    endtask

    initial begin
        int v0;
        reset_n   = 1'b0;
        io_wr     = 1'b0;
        io_rd     = 1'b0;
        io_addr   = 8'h00;
        io_din    = 8'h00;
        mem_sel   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_din   = 8'h00;
        ram_ack   = 1'b0;
        ram_rdata = 8'h00;

        repeat (2) tick();
        check("rst_req", 32'(ram_req), 32'd0);
        check("rst_wait", 32'(cpu_wait), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_mdout", 32'(mem_dout), 32'hFF);
        check("rst_valid", 32'(mem_dout_valid), 32'd0);
        check("rst_iodout", 32'(io_dout), 32'hFF);
        reset_n = 1'b1;
        tick();

        read_port(8'hFC, 1'b1, 8'hE3);
        read_port(8'hFD, 1'b1, 8'hE2);
        read_port(8'hFE, 1'b1, 8'hE1);
        read_port(8'hFF, 1'b1, 8'hE0);
        read_port(8'hFB, 1'b0, 8'hFF);

        // Upper data bits are dropped; seg2 becomes 31.
        io_write(8'hFE, 8'hFF);
        read_port(8'hFE, 1'b1, 8'hFF);
        access(1'b0, 16'h8123, 8'h00, 1, 8'h11, 19'h7C123, 1'b0);

        access(1'b0, 16'h4000, 8'h00, 3, 8'h5A, 19'h08000, 1'b0);
        access(1'b1, 16'hC001, 8'hA5, 2, 8'h00, 19'h00001, 1'b0);
        check("wr_keeps_mdout", 32'(mem_dout), 32'h5A);

        // Strobe without slot select is ignored.
        mem_sel = 1'b0;
        mem_rd  = 1'b1;
        mem_addr = 16'h1234;
        #1;
        check("nosel_wait", 32'(cpu_wait), 32'd0);
        tick();
        mem_rd = 1'b0;
        check("nosel_req", 32'(ram_req), 32'd0);

        // Segment write collides with an accepted strobe.
        io_wr   = 1'b1;
        io_addr = 8'hFC;
        io_din  = 8'h07;
        access(1'b0, 16'h0010, 8'h00, 1, 8'h33, 19'h0C010, 1'b0);
        read_port(8'hFC, 1'b1, 8'hE7);
        access(1'b0, 16'h0010, 8'h00, 2, 8'h44, 19'h1C010, 1'b1);
        read_port(8'hFC, 1'b1, 8'hE0);

        // Reset in the middle of a request.
        v0 = valid_cnt;
        mem_sel  = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = 16'h4000;
        tick();
        mem_rd = 1'b0;
        check("mid_req", 32'(ram_req), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(ram_req), 32'd0);
        check("mid_rst_wait", 32'(cpu_wait), 32'd0);
        reset_n = 1'b1;
        read_port(8'hFC, 1'b1, 8'hE3);
        read_port(8'hFE, 1'b1, 8'hE1);
        tick();
        ram_ack   = 1'b1;
        ram_rdata = 8'h77;
        tick();
        ram_ack = 1'b0;
        tick();
        tick();
        check("late_ack_valid", 32'(valid_cnt - v0), 32'd0);
        check("late_ack_mdout", 32'(mem_dout), 32'hFF);
        check("late_ack_req", 32'(ram_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/msx2_mapper_ctrl.md
Name: msx2_mapper_ctrl

Overview:
- MSX2 memory mapper control stage. It sits directly upstream of the mapped-RAM device and feeds it segment numbers and the mapper-register readback byte.
- Holds the four page segment registers written through I/O ports FCh–FFh.
- Translates slot-selected CPU memory cycles into linear RAM addresses.
- Runs the request/acknowledge handshake to the RAM arbiter, stretching the CPU with a wait signal until data is returned.

Parameters:
- SEG_BITS, 5, segment register width; mapper size = 2^SEG_BITS × 16 KB (5 → 512 KB).
- RAM_AW, SEG_BITS+14, RAM address width; must equal SEG_BITS+14.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_wr  in  1  one-cycle I/O write strobe.
- io_rd  in  1  I/O read, level while the read cycle is active.
- io_addr  in  8  I/O port address.
- io_din  in  8  I/O write data.
- io_dout  out  8  mapper register readback (data_to_mapper).
- io_dout_rq  out  1  high when io_dout must drive the bus.
- mem_sel  in  1  slot containing the mapper is selected.
- mem_rd  in  1  one-cycle memory read strobe.
- mem_wr  in  1  one-cycle memory write strobe.
- mem_addr  in  16  CPU address.
- mem_din  in  8  CPU write data.
- mem_dout  out  8  read data returned to the CPU.
- mem_dout_valid  out  1  one-cycle pulse when mem_dout is valid.
- cpu_wait  out  1  wait request to the CPU.
- ram_req  out  1  RAM request, level.
- ram_we  out  1  write qualifier for ram_req.
- ram_addr  out  RAM_AW  linear RAM address.
- ram_wdata  out  8  RAM write data.
- ram_ack  in  1  one-cycle acknowledge from the arbiter.
- ram_rdata  in  8  RAM read data, valid with ram_ack.

Behaviour:
Segment registers
- Four registers seg[0..3], SEG_BITS wide.
- Reset values: seg0=3, seg1=2, seg2=1, seg3=0.
- Write: io_wr with io_addr[7:2]=6'b111111 → seg[io_addr[1:0]] <= io_din[SEG_BITS-1:0]. Upper data bits are discarded.
- Readback is combinational: io_dout_rq = io_rd && io_addr[7:2]==6'b111111; io_dout = {ones in bits 7..SEG_BITS, seg[io_addr[1:0]]}.
- When io_dout_rq=0, io_dout = 8'hFF.

Memory FSM
- States: IDLE, REQ, DONE.
- Reset state is IDLE. Output reset values: ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, mem_dout=8'hFF, mem_dout_valid=0, cpu_wait=0.
- IDLE: (mem_rd|mem_wr) && mem_sel → latch the access and go to REQ on the next edge.
  - ram_addr <= {seg[mem_addr[15:14]], mem_addr[13:0]}.
  - ram_we <= mem_wr; ram_wdata <= mem_din.
  - mem_rd and mem_wr together: treat as a write.
  - Strobes with mem_sel=0 are ignored.
- REQ: ram_req=1 and cpu_wait=1. ram_addr, ram_we and ram_wdata are held stable.
  - On ram_ack: drop ram_req; mem_dout <= ram_rdata on reads (unchanged on writes); go to DONE.
  - ram_ack outside REQ is ignored.
- DONE: mem_dout_valid=1 for one cycle (reads only), cpu_wait=0, then IDLE.
- cpu_wait is combinational: high in REQ and in the IDLE cycle that accepts a strobe. Minimum stall is therefore 2 cycles when ram_ack arrives in the first REQ cycle.
- Total latency: strobe cycle + REQ cycles + 1 (DONE).
- New memory strobes while in REQ or DONE are ignored. The CPU is held by cpu_wait and never issues them.
- io_wr to a segment register in the same cycle as an accepted memory strobe: the address uses the old segment value; the new value applies from the next access.
- io_wr during REQ updates the register but never alters the latched ram_addr.
- reset_n asserted mid-access: FSM returns to IDLE immediately, ram_req and cpu_wait drop asynchronously, segment registers return to their reset values. A late ram_ack after reset is ignored.
- Address wrap: the segment value is used modulo 2^SEG_BITS (guaranteed by the register width).

Test Plan:
- Reset: release reset_n, read ports FCh..FFh → io_dout = E3h, E2h, E1h, E0h with io_dout_rq=1; io_rd on port FBh → io_dout_rq=0, io_dout=FFh.
- Register write: io_wr FEh with io_din=FFh → readback from FEh = FFh (seg2=31); then a read at 8123h → ram_addr = 7C123h.
- Read handshake: mem_rd at 4000h, mem_sel=1; ram_ack after 3 REQ cycles with ram_rdata=5Ah → ram_addr=08000h, ram_we=0, cpu_wait high for 4 cycles, mem_dout=5Ah, one mem_dout_valid pulse.
- Write handshake: mem_wr at C001h, din=A5h → ram_we=1, ram_addr=00001h, ram_wdata=A5h, no mem_dout_valid, cpu_wait drops the cycle after ram_ack.
- Collision: io_wr FCh=07h in the same cycle as mem_rd at 0010h → ram_addr=0C010h (old seg0=3); next read at 0010h → 1C010h.
- Mid-op reset: assert reset_n low during REQ → ram_req=0 and cpu_wait=0 with no clock edge; a subsequent ram_ack produces no mem_dout_valid.
